viterbi_decoder: RTL and testbench



---
 rtl/viterbi_pkg.sv | 17 +
 rtl/viterbi_acs.sv | 30 +++
 rtl/viterbi_decoder.sv | 104 ++++++++++
 tb/tb_viterbi_decoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/viterbi_pkg.sv
// Shared trellis definitions for the rate-1/2, K=3 code (G0=111, G1=101).
// The decoder RTL and the bench encoder/reference model both use this package.
package viterbi_pkg;

  localparam int         K        = 3;
  localparam int         N_STATES = 4;
  localparam logic [2:0] G0       = 3'b111;
  localparam logic [2:0] G1       = 3'b101;

  // Encoder register is {d, s0, s1}. Result is {G1 bit, G0 bit}, matching the code_in layout.
  function automatic logic [1:0] exp_pair(input logic [1:0] state, input logic d);
    logic [2:0] reg_v;
    reg_v = {d, state[0], state[1]};
    return {^(reg_v & G1), ^(reg_v & G0)};
  endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: two saturating candidates, keep the smaller.
// On a tie the first predecessor (lower state index) wins.
module viterbi_acs #(
  parameter int PM_W = 5
) (
  input  logic [PM_W-1:0] pm_a,
  input  logic [PM_W-1:0] pm_b,
  input  logic [1:0]      bm_a,
  input  logic [1:0]      bm_b,
  output logic [PM_W-1:0] pm_new,
  output logic            dec
);

  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a, input logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? '1 : s[PM_W-1:0];
  endfunction

  logic [PM_W-1:0] cand_a;
  logic [PM_W-1:0] cand_b;

  always_comb begin
    cand_a = sat_add(pm_a, bm_a);
    cand_b = sat_add(pm_b, bm_b);
    dec    = (cand_b < cand_a);
    pm_new = dec ? cand_b : cand_a;
  end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, K=3 rate-1/2, register-exchange survivors.
// One symbol per cycle in, one decoded bit out TB_DEPTH symbols later.
module viterbi_decoder
  import viterbi_pkg::*;
#(
  parameter int TB_DEPTH = 16,
  parameter int PM_W     = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            code_valid,
  input  logic [1:0]      code_in,
  output logic            data_out,
  output logic            data_valid,
  output logic [PM_W-1:0] best_metric
);

  localparam int               CNT_W   = $clog2(TB_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(TB_DEPTH);

  function automatic logic [1:0] hamming(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[0]} + {1'b0, x[1]};
  endfunction

  logic [PM_W-1:0]     pm_p0    [N_STATES];
  logic [TB_DEPTH-1:0] surv_p0  [N_STATES];
  logic [CNT_W-1:0]    sym_cnt;
  logic [CNT_W-1:0]    sym_cnt_next;

  logic [1:0]          bm_a     [N_STATES];
  logic [1:0]          bm_b     [N_STATES];
  logic [PM_W-1:0]     acs_pm   [N_STATES];
  logic [N_STATES-1:0] dec;
  logic [PM_W-1:0]     pm_norm  [N_STATES];
  logic [TB_DEPTH-1:0] surv_new [N_STATES];
  logic [PM_W-1:0]     pm_min;
  logic [1:0]          best;
  logic [1:0]          win;

  // Branch metrics: predecessors of {n1,n0} are n1 and 2+n1, both driven by d=n0.
  always_comb begin
    for (int n = 0; n < N_STATES; n++) begin
      bm_a[n] = hamming(code_in, exp_pair({1'b0, n[1]}, n[0]));
      bm_b[n] = hamming(code_in, exp_pair({1'b1, n[1]}, n[0]));
    end
  end

  for (genvar g = 0; g < N_STATES; g++) begin : g_acs
    viterbi_acs #(.PM_W(PM_W)) u_acs (
      .pm_a   (pm_p0[g >> 1]),
      .pm_b   (pm_p0[2 + (g >> 1)]),
      .bm_a   (bm_a[g]),
      .bm_b   (bm_b[g]),
      .pm_new (acs_pm[g]),
      .dec    (dec[g])
    );
  end

  // Normalise, pick the lowest-index minimal state, exchange survivors.
  always_comb begin
    pm_min = acs_pm[0];
    for (int n = 1; n < N_STATES; n++)
      if (acs_pm[n] < pm_min) pm_min = acs_pm[n];
    best = '0;
    for (int n = N_STATES - 1; n >= 0; n--)
      if (acs_pm[n] == pm_min) best = 2'(n);
    win = '0;
    for (int n = 0; n < N_STATES; n++) begin
      pm_norm[n]  = acs_pm[n] - pm_min;
      win         = {dec[n], n[1]};
      surv_new[n] = {surv_p0[win][TB_DEPTH-2:0], n[0]};
    end
  end

  assign sym_cnt_next = (sym_cnt == DEPTH_C) ? DEPTH_C : sym_cnt + 1'b1;

  // Stage p0: metrics, survivors, counter and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < N_STATES; n++) begin
        pm_p0[n]   <= (n == 0) ? '0 : '1;
        surv_p0[n] <= '0;
      end
      sym_cnt     <= '0;
      data_out    <= 1'b0;
      data_valid  <= 1'b0;
      best_metric <= '0;
    end else begin
      data_valid <= code_valid && (sym_cnt_next >= DEPTH_C);
      if (code_valid) begin
        for (int n = 0; n < N_STATES; n++) begin
          pm_p0[n]   <= pm_norm[n];
          surv_p0[n] <= surv_new[n];
        end
        sym_cnt     <= sym_cnt_next;
        data_out    <= surv_new[best][TB_DEPTH-1];
        best_metric <= pm_norm[best];
      end
    end
  end

endmodule

// File: tb/tb_viterbi_decoder.sv
// Scoreboard bench for viterbi_decoder: encoder + independent forward-push Viterbi model,
// expected bits queued at drive time and compared on every data_valid pulse.
`timescale 1ns/1ps
module tb_viterbi_decoder;
  import viterbi_pkg::*;

  localparam int TB_DEPTH = 16;
  localparam int PM_W     = 5;
  localparam int PM_MAX   = (1 << PM_W) - 1;

  logic            clk        = 1'b0;
  logic            reset      = 1'b1;
  logic            code_valid = 1'b0;
  logic [1:0]      code_in    = '0;
  logic            data_out;
  logic            data_valid;
  logic [PM_W-1:0] best_metric;

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .code_valid  (code_valid),
    .code_in     (code_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .best_metric (best_metric)
  );

  always #5 clk = ~clk;

  int              n_checks = 0;
  int              n_errors = 0;
  int              n_pulses = 0;
  bit              exp_q[$];
  bit              truth_q[$];
  logic [1:0]      enc_st = '0;
  bit              use_model = 1'b0;
  logic            sampled_vld = 1'b0;
  int              mpm [N_STATES];
  longint unsigned msv [N_STATES];
  int              mcnt;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < N_STATES; s++) begin
      mpm[s] = (s == 0) ? 0 : PM_MAX;
      msv[s] = 0;
    end
    mcnt = 0;
  endfunction

  // Forward (push) formulation: each state offers both successors; strict < keeps the lower predecessor.
  function automatic void model_step(input logic [1:0] sym, output bit obit, output bit ovld);
    int              npm [N_STATES];
    longint unsigned nsv [N_STATES];
    int              nx, c, mn, bst;
    logic [1:0]      e, ps;
    for (int s = 0; s < N_STATES; s++) begin
      npm[s] = 1 << 30;
      nsv[s] = 0;
    end
    for (int p = 0; p < N_STATES; p++) begin
      for (int d = 0; d < 2; d++) begin
        ps = 2'(p);
        nx = ((p & 1) << 1) | d;
        e  = exp_pair(ps, d[0]);
        c  = mpm[p] + int'(e[0] ^ sym[0]) + int'(e[1] ^ sym[1]);
        if (c > PM_MAX) c = PM_MAX;
        if (c < npm[nx]) begin
          npm[nx] = c;
          nsv[nx] = (msv[p] << 1) | 64'(d);
        end
      end
    end
    mn  = npm[0];
    bst = 0;
    for (int s = 1; s < N_STATES; s++)
      if (npm[s] < mn) begin
        mn  = npm[s];
        bst = s;
      end
    for (int s = 0; s < N_STATES; s++) begin
      mpm[s] = npm[s] - mn;
      msv[s] = nsv[s];
    end
    if (mcnt < TB_DEPTH) mcnt++;
    ovld = (mcnt >= TB_DEPTH);
    obit = nsv[bst][TB_DEPTH-1];
  endfunction

  always @(posedge clk) sampled_vld <= code_valid;

  always @(negedge clk) begin
    if (data_valid) begin
      n_pulses++;
      check("vld_after_sym", 32'(sampled_vld), 32'd1);
      check("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        check("best_metric", 32'(best_metric), 32'd0);
      end
    end
  end

  task automatic drive_sym(input logic [1:0] sym, input bit d);
    bit obit, ovld, t;
    @(negedge clk);
    code_valid = 1'b1;
    code_in    = sym;
    model_step(sym, obit, ovld);
    truth_q.push_back(d);
    if (ovld) begin
      t = truth_q.pop_front();
      exp_q.push_back(use_model ? obit : t);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    code_valid = 1'b0;
    code_in    = 2'($urandom);
  endtask

  task automatic send_bit(input bit d, input logic [1:0] err, input int gap);
    logic [1:0] sym;
    sym    = exp_pair(enc_st, d) ^ err;
    enc_st = {enc_st[0], d};
    drive_sym(sym, d);
    repeat (gap) idle();
  endtask

  task automatic drain(input string tag, input int pulses);
    repeat (3) idle();
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_pulses"}, 32'(n_pulses), 32'(pulses));
  endtask

  // Reset is held with a valid symbol present: that symbol must be discarded.
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    code_valid = 1'b1;
    code_in    = 2'($urandom);
    @(negedge clk);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_best_metric", 32'(best_metric), 32'd0);
    reset      = 1'b0;
    code_valid = 1'b0;
    exp_q.delete();
    truth_q.delete();
    model_reset();
    enc_st   = '0;
    n_pulses = 0;
  endtask

  task automatic directed(input string tag, input int err_idx, input int gap);
    bit [3:0] head;
    head = 4'b1101;
    do_reset();
    for (int i = 0; i < 20; i++)
      send_bit((i < 4) ? head[i] : 1'b0, (i == err_idx) ? 2'b01 : 2'b00, gap);
    drain(tag, 5);
  endtask

  initial begin
    int last_err;
    logic [1:0] m;
    model_reset();
    repeat (2) @(posedge clk);

    do_reset();
    for (int i = 0; i < 40; i++) send_bit(1'b0, 2'b00, 0);
    drain("zeros", 25);

    directed("pattern", -1, 0);
    directed("one_err", 2, 0);
    directed("gapped", -1, 3);

    do_reset();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom), 2'b00, 0);
    do_reset();
    for (int i = 0; i < 30; i++) send_bit(1'($urandom), 2'b00, 0);
    for (int i = 0; i < TB_DEPTH; i++) send_bit(1'b0, 2'b00, 0);
    drain("midrst", 30 + TB_DEPTH - TB_DEPTH + 1);

    use_model = 1'b1;
    do_reset();
    last_err = -100;
    for (int i = 0; i < 10000 + TB_DEPTH; i++) begin
      m = 2'b00;
      if (i - last_err >= 8) begin
        if ($urandom_range(0, 99) == 0) m = 2'b01;
        else if ($urandom_range(0, 99) == 0) m = 2'b10;
        if (m != 2'b00) last_err = i;
      end
      send_bit((i < 10000) ? 1'($urandom) : 1'b0, m, 0);
    end
    drain("random", 10000 + 1);
    use_model = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
